alu_cmp: RTL and testbench

ALU_CMP -- requirements
Module: alu_cmp

---
 rtl/alu_cmp.sv | 193 +++++++++++++++++++
 tb/tb_alu_cmp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmp.sv
// Compare/branch-condition unit: one pipeline stage (S1) feeding an in-order result FIFO.
// Optional feature macro ALU_CMP_BYPASS_EN: write straight into an idle FIFO (1-cycle latency).
module alu_cmp #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [XLEN-1:0]       arg0,
    input  logic [XLEN-1:0]       arg1,
    input  logic [3:0]            cmd,
    input  logic [REG_ADDR_W-1:0] i_rd,
    output logic                  busy,
    output logic                  i_error,
    output logic [XLEN-1:0]       res,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic                  o_error,
    output logic                  valid,
    output logic                  req,
    input  logic                  clear,
    input  logic                  flush
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned OccW = CntW + 1;

    typedef enum logic [3:0] {
        CmdSlt  = 4'd0,
        CmdSltu = 4'd1,
        CmdBeq  = 4'd2,
        CmdBne  = 4'd3,
        CmdBlt  = 4'd4,
        CmdBge  = 4'd5,
        CmdBltu = 4'd6,
        CmdBgeu = 4'd7
    } cmd_e;

    // Comparison datapath
    logic            lt_s;
    logic            lt_u;
    logic            eq;
    logic            cmp_bit;
    logic            cmd_ill;
    logic [XLEN-1:0] new_res;

    assign lt_s = $signed(arg0) < $signed(arg1);
    assign lt_u = arg0 < arg1;
    assign eq   = arg0 == arg1;

    always_comb begin
        cmp_bit = 1'b0;
        cmd_ill = 1'b0;
        case (cmd)
            CmdSlt:  cmp_bit = lt_s;
            CmdSltu: cmp_bit = lt_u;
            CmdBeq:  cmp_bit = eq;
            CmdBne:  cmp_bit = ~eq;
            CmdBlt:  cmp_bit = lt_s;
            CmdBge:  cmp_bit = ~lt_s;
            CmdBltu: cmp_bit = lt_u;
            CmdBgeu: cmp_bit = ~lt_u;
            default: cmd_ill = 1'b1;
        endcase
    end

    assign new_res = {{(XLEN-1){1'b0}}, cmp_bit};

    // Stage S1 and FIFO state
    logic                  s1_v_q, s1_v_d;
    logic [XLEN-1:0]       s1_res_q, s1_res_d;
    logic [REG_ADDR_W-1:0] s1_rd_q, s1_rd_d;
    logic                  s1_err_q, s1_err_d;
    logic                  i_error_q, i_error_d;

    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;

    logic [XLEN-1:0]       mem_res_q [DEPTH];
    logic [REG_ADDR_W-1:0] mem_rd_q  [DEPTH];
    logic                  mem_err_q [DEPTH];

    logic                  accept;
    logic                  bypass;
    logic                  push;
    logic                  pop;
    logic [XLEN-1:0]       push_res;
    logic [REG_ADDR_W-1:0] push_rd;
    logic                  push_err;
    logic [OccW-1:0]       occ;

    // S1 must count toward occupancy so its result always has a FIFO slot next edge
    assign occ   = {1'b0, count_q} + OccW'(s1_v_q);
    assign busy  = occ >= OccW'(DEPTH);
    assign valid = count_q != '0;
    assign req   = count_q >= CntW'(DEPTH / 2);

    assign accept = i_valid & ~busy & ~flush;

`ifdef ALU_CMP_BYPASS_EN
    assign bypass = accept & (count_q == '0) & ~s1_v_q;
`else
    assign bypass = 1'b0;
`endif

    assign push = s1_v_q | bypass;
    assign pop  = clear & valid;

    always_comb begin
        push_res = s1_res_q;
        push_rd  = s1_rd_q;
        push_err = s1_err_q;
        if (bypass) begin
            push_res = cmd_ill ? '0 : new_res;
            push_rd  = i_rd;
            push_err = cmd_ill;
        end
    end

    always_comb begin
        s1_v_d    = accept & ~bypass;
        s1_res_d  = s1_res_q;
        s1_rd_d   = s1_rd_q;
        s1_err_d  = s1_err_q;
        i_error_d = accept & cmd_ill;
        if (accept) begin
            s1_res_d = cmd_ill ? '0 : new_res;
            s1_rd_d  = i_rd;
            s1_err_d = cmd_ill;
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_res_q  <= '0;
            s1_rd_q   <= '0;
            s1_err_q  <= 1'b0;
            i_error_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else if (flush) begin
            s1_v_q    <= 1'b0;
            i_error_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_res_q  <= s1_res_d;
            s1_rd_q   <= s1_rd_d;
            s1_err_q  <= s1_err_d;
            i_error_q <= i_error_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: every output read is gated by valid
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem_res_q[wr_ptr_q] <= push_res;
            mem_rd_q[wr_ptr_q]  <= push_rd;
            mem_err_q[wr_ptr_q] <= push_err;
        end
    end

    assign i_error = i_error_q;
    assign res     = valid ? mem_res_q[rd_ptr_q] : '0;
    assign o_rd    = valid ? mem_rd_q[rd_ptr_q]  : '0;
    assign o_error = valid & mem_err_q[rd_ptr_q];

endmodule

// File: tb/tb_alu_cmp.sv
// Directed self-checking bench for alu_cmp (XLEN=32, REG_ADDR_W=5, DEPTH=4).
module tb_alu_cmp;

`ifdef ALU_CMP_BYPASS_EN
    localparam logic Byp = 1'b1;
`else
    localparam logic Byp = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [31:0] arg0;
    logic [31:0] arg1;
    logic [3:0]  cmd;
    logic [4:0]  i_rd;
    logic        busy;
    logic        i_error;
    logic [31:0] res;
    logic [4:0]  o_rd;
    logic        o_error;
    logic        valid;
    logic        req;
    logic        clear;
    logic        flush;

    int n_assert = 0;
    int n_fail   = 0;
    int acc;
    int acc2;
    logic req_seen [8];

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t vecs [12];

    alu_cmp #(
        .XLEN      (32),
        .REG_ADDR_W(5),
        .DEPTH     (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_valid(i_valid),
        .arg0   (arg0),
        .arg1   (arg1),
        .cmd    (cmd),
        .i_rd   (i_rd),
        .busy   (busy),
        .i_error(i_error),
        .res    (res),
        .o_rd   (o_rd),
        .o_error(o_error),
        .valid  (valid),
        .req    (req),
        .clear  (clear),
        .flush  (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        i_valid = 1'b1;
        cmd     = c;
        arg0    = a;
        arg1    = b;
        i_rd    = rd;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [4:0] rd, input logic [31:0] r);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_rd"}, 32'(o_rd), 32'(rd));
        check({tag, "_res"}, res, r);
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'd0, 32'd5,          32'hFFFF_FFFD, 32'd0};
        vecs[1]  = '{4'd0, 32'hFFFF_FFFD,  32'd5,         32'd1};
        vecs[2]  = '{4'd1, 32'd5,          32'hFFFF_FFFD, 32'd1};
        vecs[3]  = '{4'd2, 32'd7,          32'd7,         32'd1};
        vecs[4]  = '{4'd3, 32'd7,          32'd7,         32'd0};
        vecs[5]  = '{4'd3, 32'd1,          32'd2,         32'd1};
        vecs[6]  = '{4'd4, 32'h8000_0000,  32'd0,         32'd1};
        vecs[7]  = '{4'd5, 32'h8000_0000,  32'd0,         32'd0};
        vecs[8]  = '{4'd5, 32'd4,          32'd4,         32'd1};
        vecs[9]  = '{4'd6, 32'h8000_0000,  32'd0,         32'd0};
        vecs[10] = '{4'd6, 32'd3,          32'd4,         32'd1};
        vecs[11] = '{4'd7, 32'd3,          32'd4,         32'd0};

        rst = 1'b1; i_valid = 1'b0; arg0 = '0; arg1 = '0; cmd = '0; i_rd = '0;
        clear = 1'b0; flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_req", 32'(req), 32'd0);
        check("rst_ierr", 32'(i_error), 32'd0);
        check("rst_res", res, 32'd0);
        check("rst_ord", 32'(o_rd), 32'd0);
        check("rst_oerr", 32'(o_error), 32'd0);

        // Signed vs unsigned less-than, with latency
        issue(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd1);
        check("lat_valid_e1", 32'(valid), 32'(Byp));
        check("legal_ierr", 32'(i_error), 32'd0);
        issue(4'd1, 32'hFFFF_FFFF, 32'd1, 5'd2);
        check("lat_valid_e2", 32'(valid), 32'd1);
        tick();
        check("req_cnt2", 32'(req), 32'd1);
        pop_check("slt", 5'd1, 32'd1);
        pop_check("sltu", 5'd2, 32'd0);
        check("drain1_valid", 32'(valid), 32'd0);

        // BGEU / BEQ pair
        issue(4'd7, 32'h8000_0000, 32'd5, 5'd3);
        issue(4'd2, 32'd7, 32'd8, 5'd4);
        tick();
        pop_check("bgeu", 5'd3, 32'd1);
        pop_check("beq", 5'd4, 32'd0);
        check("drain2_valid", 32'(valid), 32'd0);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].c, vecs[i].a, vecs[i].b, 5'(i + 10));
            tick();
            pop_check($sformatf("vec%0d", i), 5'(i + 10), vecs[i].r);
        end
        check("vec_drain_valid", 32'(valid), 32'd0);

        // Back-pressure: issue every cycle with no drain
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            i_valid = 1'b1; cmd = 4'd2; arg0 = 32'(k); arg1 = 32'(k); i_rd = 5'(k);
            if (!busy) acc++;
            tick();
            req_seen[k] = req;
        end
        check("full_accepts", 32'(acc), 32'd4);
        check("full_busy", 32'(busy), 32'd1);
        check("req_cnt1", 32'(req_seen[1]), 32'd0);
        check("req_cnt2b", 32'(req_seen[2]), 32'd1);
        check("req_full", 32'(req_seen[7]), 32'd1);
        acc2 = 0;
        i_rd = 5'd20; arg0 = 32'd7; arg1 = 32'd7;
        clear = 1'b1;
        if (!busy) acc2++;
        tick();
        clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!busy) acc2++;
            tick();
        end
        i_valid = 1'b0;
        check("one_more_accept", 32'(acc2), 32'd1);
        check("refull_busy", 32'(busy), 32'd1);
        pop_check("bp_a", 5'd1, 32'd1);
        pop_check("bp_b", 5'd2, 32'd1);
        pop_check("bp_c", 5'd3, 32'd1);
        pop_check("bp_d", 5'd20, 32'd1);
        check("bp_drain_valid", 32'(valid), 32'd0);

        // Illegal opcode
        issue(4'd12, 32'd3, 32'd3, 5'd9);
        check("ill_ierr_pulse", 32'(i_error), 32'd1);
        tick();
        check("ill_ierr_low", 32'(i_error), 32'd0);
        check("ill_oerr", 32'(o_error), 32'd1);
        pop_check("ill", 5'd9, 32'd0);
        check("ill_oerr_empty", 32'(o_error), 32'd0);

        // Simultaneous push and pop at count 3 across the pointer wrap
        do_reset();
        issue(4'd2, 32'd1, 32'd1, 5'd1);
        issue(4'd2, 32'd1, 32'd2, 5'd2);
        issue(4'd3, 32'd1, 32'd2, 5'd3);
        tick();
        check("c3_busy", 32'(busy), 32'd0);
        issue(4'd6, 32'd1, 32'd2, 5'd4);
        check("c3s1_busy", 32'(busy), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("pp_busy", 32'(busy), 32'd0);
        check("pp_head", 32'(o_rd), 32'd2);
        tick();
        check("pp_hold_head", 32'(o_rd), 32'd2);
        pop_check("pp_a", 5'd2, 32'd0);
        pop_check("pp_b", 5'd3, 32'd1);
        pop_check("pp_c", 5'd4, 32'd1);
        check("pp_drain_valid", 32'(valid), 32'd0);

        // Flush with three entries plus S1 occupied
        issue(4'd2, 32'd1, 32'd1, 5'd5);
        issue(4'd2, 32'd1, 32'd1, 5'd6);
        issue(4'd2, 32'd1, 32'd1, 5'd7);
        tick();
        issue(4'd2, 32'd1, 32'd1, 5'd8);
        flush = 1'b1; clear = 1'b1;
        tick();
        flush = 1'b0; clear = 1'b0;
        check("fl_valid", 32'(valid), 32'd0);
        check("fl_busy", 32'(busy), 32'd0);
        check("fl_req", 32'(req), 32'd0);
        check("fl_res", res, 32'd0);
        tick(); tick(); tick();
        check("fl_no_stale", 32'(valid), 32'd0);

        // Reset with three entries plus S1 occupied
        issue(4'd2, 32'd1, 32'd1, 5'd5);
        issue(4'd2, 32'd1, 32'd1, 5'd6);
        issue(4'd2, 32'd1, 32'd1, 5'd7);
        tick();
        issue(4'd2, 32'd1, 32'd1, 5'd8);
        do_reset();
        check("rs_valid", 32'(valid), 32'd0);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_req", 32'(req), 32'd0);
        tick(); tick(); tick();
        check("rs_no_stale", 32'(valid), 32'd0);

        // Flush suppresses a same-edge accept and its i_error
        i_valid = 1'b1; cmd = 4'd12; i_rd = 5'd9; flush = 1'b1;
        tick();
        i_valid = 1'b0; flush = 1'b0;
        check("flacc_ierr", 32'(i_error), 32'd0);
        check("flacc_valid1", 32'(valid), 32'd0);
        tick();
        check("flacc_valid2", 32'(valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
